seq_divider: RTL

//   Multicycle restoring integer divider, parametrised in WIDTH, one quotient bit per cycle.
//   Per-operation signed/unsigned mode, quotient and remainder outputs, and an exception flag
//   for divide-by-zero and signed overflow. Used by the processor's multdiv path; start/ready

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider_step.sv | 28 ++
 rtl/seq_divider.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding.
// The multiplier control imports the same state names.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/ready handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rem;
  logic             exp;
  logic             ready;
  logic             busy;

  modport master (
    output start, is_signed, A, B,
    input  out, rem, exp, ready, busy
  );

  modport slave (
    input  start, is_signed, A, B,
    output out, rem, exp, ready, busy
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift {acc, dq} left and subtract the divisor if it fits.
module seq_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] dq_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] dq_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // acc < divisor keeps the trial inside [-divisor, divisor-1], so WIDTH+1 bits suffice.
  always_comb begin
    shifted = {acc_in, dq_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[WIDTH]) begin
      acc_out = shifted[WIDTH-1:0];
      dq_out  = {dq_in[WIDTH-2:0], 1'b0};
    end else begin
      acc_out = trial[WIDTH-1:0];
      dq_out  = {dq_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multicycle restoring divider, signed/unsigned per operation, with divide-by-zero
// and signed-overflow exception results. One quotient bit per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clock,
  input logic          reset,
  seq_divider_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] acc_q, acc_d, dq_q, dq_d, div_q, div_d;
  logic [WIDTH-1:0] out_q, out_d, rem_q, rem_d;
  logic             exp_q, exp_d;

  logic [WIDTH-1:0] step_acc, step_dq, a_mag, b_mag;
  logic             q_neg, r_neg, div_zero, sgn_ovf;

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .dq_in   (dq_q),
    .divisor (div_q),
    .acc_out (step_acc),
    .dq_out  (step_dq)
  );

  // Raw operands stay registered for the whole operation; signs and exceptions derive from them.
  always_comb begin
    q_neg    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg    = sgn_q & a_q[WIDTH-1];
    a_mag    = r_neg ? -a_q : a_q;
    b_mag    = (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
    div_zero = (b_q == '0);
    sgn_ovf  = sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  end

  // The first RUN cycle converts operands to magnitudes, keeping negation off the start path;
  // the following WIDTH cycles each produce one quotient bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    dq_d    = dq_q;
    div_d   = div_q;
    out_d   = out_q;
    rem_d   = rem_q;
    exp_d   = exp_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = bus.A;
          b_d     = bus.B;
          sgn_d   = bus.is_signed;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          acc_d = '0;
          dq_d  = a_mag;
          div_d = b_mag;
        end else begin
          acc_d = step_acc;
          dq_d  = step_dq;
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (div_zero) begin
          out_d = '1;
          rem_d = a_q;
          exp_d = 1'b1;
        end else if (sgn_ovf) begin
          out_d = a_q;
          rem_d = '0;
          exp_d = 1'b1;
        end else begin
          out_d = q_neg ? -dq_q : dq_q;
          rem_d = r_neg ? -acc_q : acc_q;
          exp_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.rem   = rem_q;
  assign bus.exp   = exp_q;
  assign bus.ready = (state_q == ST_DONE);
  assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_FIX);

endmodule
